// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg                                                                    |
// | Mode encodings and sequencer state type shared by the mode-switch logic.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vga_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_640X480  = 2'd0;
    localparam mode_t MODE_768X576  = 2'd1;
    localparam mode_t MODE_800X600  = 2'd2;
    localparam mode_t MODE_1024X768 = 2'd3;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_HOLD       = 3'd2,
        ST_LOCK       = 3'd3,
        ST_SETTLE     = 3'd4
    } seq_state_t;

    // Wide enough for the larger of the two terminal counts, plus headroom bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mode_seq_timer                                                             |
// | Loadable saturating down-counter with zero flag, shared by HOLD and SETTLE.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mode_seq_timer #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VALUE;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - ONE;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/video_mode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_mode_sequencer                                                       |
// | Sequences live VGA mode changes: frame wait, blank, generator reset,       |
// | settle frames, unblank. VGA_MODE_CLKSEL_EN adds clk_sel/clk_locked and a   |
// | LOCK state that waits for the pixel clock to relock after HOLD.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module video_mode_sequencer
    import vga_pkg::*;
#(
    parameter mode_t DEFAULT_MODE  = MODE_640X480,
    parameter int    RESET_CYCLES  = 4,
    parameter int    SETTLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    input  logic       frame_start,
    output logic [1:0] mode,
    output logic       gen_reset,
    output logic       blank,
    output logic       mode_ack,
    output logic       busy
`ifdef VGA_MODE_CLKSEL_EN
    ,
    output logic [1:0] clk_sel,
    input  logic       clk_locked
`endif
);

    localparam int               CNT_W       = cnt_width(RESET_CYCLES, SETTLE_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_FRAMES - 1);

    seq_state_t       state_q;
    mode_t            mode_q;
    mode_t            pending_q;
    logic             switch_q;
    logic             gen_reset_q;
    logic             blank_q;
    logic             req_ready_q;
    logic             mode_ack_q;
    logic             busy_q;

    logic             timer_load;
    logic             timer_dec;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;

    mode_seq_timer #(
        .WIDTH       (CNT_W),
        .RESET_VALUE (HOLD_LOAD)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (timer_load),
        .dec_i        (timer_dec),
        .load_value_i (timer_value),
        .zero_o       (timer_zero)
    );

    always_comb begin
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        timer_value = HOLD_LOAD;
        case (state_q)
            ST_WAIT_FRAME: begin
                if (frame_start) begin
                    timer_load  = 1'b1;
                    timer_value = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (!timer_zero) begin
                    timer_dec = 1'b1;
                end
`ifndef VGA_MODE_CLKSEL_EN
                else begin
                    timer_load  = 1'b1;
                    timer_value = SETTLE_LOAD;
                end
`endif
            end
`ifdef VGA_MODE_CLKSEL_EN
            ST_LOCK: begin
                if (clk_locked) begin
                    timer_load  = 1'b1;
                    timer_value = SETTLE_LOAD;
                end
            end
`endif
            ST_SETTLE: begin
                timer_dec = frame_start;
            end
            default: begin
                timer_load  = 1'b0;
                timer_dec   = 1'b0;
            end
        endcase
    end

    // switch_q separates a requested switch from power-up entry: only the former acks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            mode_q      <= DEFAULT_MODE;
            pending_q   <= DEFAULT_MODE;
            switch_q    <= 1'b0;
            gen_reset_q <= 1'b1;
            blank_q     <= 1'b1;
            req_ready_q <= 1'b0;
            mode_ack_q  <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            mode_ack_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (req_valid && req_ready_q) begin
                        if (req_mode == mode_q) begin
                            mode_ack_q <= 1'b1;
                        end else begin
                            pending_q   <= req_mode;
                            switch_q    <= 1'b1;
                            state_q     <= ST_WAIT_FRAME;
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                ST_WAIT_FRAME: begin
                    if (frame_start) begin
                        state_q     <= ST_HOLD;
                        mode_q      <= pending_q;
                        gen_reset_q <= 1'b1;
                        blank_q     <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (timer_zero) begin
`ifdef VGA_MODE_CLKSEL_EN
                        state_q     <= ST_LOCK;
`else
                        state_q     <= ST_SETTLE;
                        gen_reset_q <= 1'b0;
`endif
                    end
                end
`ifdef VGA_MODE_CLKSEL_EN
                ST_LOCK: begin
                    if (clk_locked) begin
                        state_q     <= ST_SETTLE;
                        gen_reset_q <= 1'b0;
                    end
                end
`endif
                ST_SETTLE: begin
                    if (frame_start && timer_zero) begin
                        state_q     <= ST_RUN;
                        blank_q     <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        mode_ack_q  <= switch_q;
                        switch_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_HOLD;
                    gen_reset_q <= 1'b1;
                    blank_q     <= 1'b1;
                    req_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    assign mode      = mode_q;
    assign gen_reset = gen_reset_q;
    assign blank     = blank_q;
    assign req_ready = req_ready_q;
    assign mode_ack  = mode_ack_q;
    assign busy      = busy_q;
`ifdef VGA_MODE_CLKSEL_EN
    assign clk_sel   = mode_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_mode_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_video_mode_sequencer                                                    |
// | Directed + random stimulus against an event-count model of mode switching. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_video_mode_sequencer;

    localparam int         RESET_CYCLES  = 4;
    localparam int         SETTLE_FRAMES = 2;
    localparam logic [1:0] DEFAULT_MODE  = 2'd0;
`ifdef VGA_MODE_CLKSEL_EN
    localparam bit         LOCK_EN = 1'b1;
`else
    localparam bit         LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_mode = 2'd0;
    logic       frame_start = 1'b0;
    logic       clk_locked = 1'b1;
    logic       req_ready, gen_reset, blank, mode_ack, busy;
    logic [1:0] mode;
`ifdef VGA_MODE_CLKSEL_EN
    logic [1:0] clk_sel;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;
    int accept_cnt = 0;

    // Model: outstanding work expressed as counts of cycles / frames still owed.
    logic [1:0] m_mode    = DEFAULT_MODE;
    logic [1:0] m_pending = DEFAULT_MODE;
    bit         m_wait    = 1'b0;
    bit         m_lock    = 1'b0;
    bit         m_switch  = 1'b0;
    bit         m_ack     = 1'b0;
    int         m_hold    = RESET_CYCLES;
    int         m_frames  = 0;

    video_mode_sequencer #(
        .DEFAULT_MODE  (DEFAULT_MODE),
        .RESET_CYCLES  (RESET_CYCLES),
        .SETTLE_FRAMES (SETTLE_FRAMES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_ready   (req_ready),
        .frame_start (frame_start),
        .mode        (mode),
        .gen_reset   (gen_reset),
        .blank       (blank),
        .mode_ack    (mode_ack),
        .busy        (busy)
`ifdef VGA_MODE_CLKSEL_EN
        ,
        .clk_sel     (clk_sel),
        .clk_locked  (clk_locked)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mode   = DEFAULT_MODE;
                m_wait   = 1'b0;
                m_lock   = 1'b0;
                m_switch = 1'b0;
                m_ack    = 1'b0;
                m_hold   = RESET_CYCLES;
                m_frames = 0;
            end else begin
                m_ack = 1'b0;
                if (!(m_wait || m_lock || m_hold > 0 || m_frames > 0)) begin
                    if (req_valid) begin
                        if (req_mode == m_mode) begin
                            m_ack = 1'b1;
                        end else begin
                            m_pending = req_mode;
                            m_wait    = 1'b1;
                            m_switch  = 1'b1;
                        end
                    end
                end else if (m_wait) begin
                    if (frame_start) begin
                        m_wait = 1'b0;
                        m_mode = m_pending;
                        m_hold = RESET_CYCLES;
                    end
                end else if (m_hold > 0) begin
                    m_hold--;
                    if (m_hold == 0) begin
                        if (LOCK_EN) m_lock = 1'b1;
                        else         m_frames = SETTLE_FRAMES;
                    end
                end else if (m_lock) begin
                    if (clk_locked) begin
                        m_lock   = 1'b0;
                        m_frames = SETTLE_FRAMES;
                    end
                end else if (m_frames > 0) begin
                    if (frame_start) begin
                        m_frames--;
                        if (m_frames == 0) begin
                            m_ack    = m_switch;
                            m_switch = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit e_rst, e_busy;
        forever begin
            @(negedge clk);
            e_rst  = (m_hold > 0) || m_lock;
            e_busy = m_wait || e_rst || (m_frames > 0);
            chk("mode",      mode,      m_mode);
            chk("gen_reset", gen_reset, e_rst);
            chk("blank",     blank,     e_rst || (m_frames > 0));
            chk("busy",      busy,      e_busy);
            chk("req_ready", req_ready, !e_busy);
            chk("mode_ack",  mode_ack,  m_ack);
`ifdef VGA_MODE_CLKSEL_EN
            chk("clk_sel",   clk_sel,   m_mode);
`endif
            if (mode_ack === 1'b1) ack_cnt++;
            if (req_valid && req_ready === 1'b1) accept_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_fs();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic request(input logic [1:0] m);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        tick();
        req_valid = 1'b1;
        req_mode  = m;
        while (!got && n < 400) begin
            @(negedge clk);
            if (req_ready === 1'b1) got = 1'b1;
            n++;
        end
        tick();
        req_valid = 1'b0;
        if (!got) chk("req_accept_timeout", 0, 1);
    endtask

    initial begin
        int  cnt;
        int  ack0;
        int  acc0;
        bit  rdy;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gen_reset", gen_reset, 1);
        chk("rst_blank",     blank,     1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mode",      mode,      DEFAULT_MODE);
        @(posedge clk); #2;
        reset = 1'b0;

        // Power-up sequence
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt += int'(gen_reset);
        end
        chk("pwr_gen_reset_cycles", cnt, LOCK_EN ? 5 : 4);
        pulse_fs();
        @(negedge clk);
        chk("pwr_blank_one_frame", blank, 1);
        pulse_fs();
        @(negedge clk);
        chk("pwr_busy",      busy,      0);
        chk("pwr_req_ready", req_ready, 1);
        chk("pwr_no_ack",    ack_cnt,   0);

        // 0 -> 3 switch
        request(2'd3);
        @(negedge clk);
        chk("sw_mode_before_frame", mode, 0);
        chk("sw_blank_live",        blank, 0);
        repeat (5) tick();
        @(negedge clk);
        chk("sw_mode_still_0", mode, 0);
        pulse_fs();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt += int'(gen_reset);
        end
        chk("sw_gen_reset_cycles", cnt, LOCK_EN ? 5 : 4);
        chk("sw_mode_new", mode, 3);
        pulse_fs();
        @(negedge clk);
        chk("sw_no_early_ack", mode_ack, 0);
        pulse_fs();
        @(negedge clk);
        chk("sw_ack",     mode_ack, 1);
        chk("sw_unblank", blank,    0);
        @(negedge clk);
        chk("sw_ack_one_cycle", mode_ack, 0);

        // Same-mode request
        request(2'd3);
        @(negedge clk);
        chk("same_ack",       mode_ack,  1);
        chk("same_blank",     blank,     0);
        chk("same_gen_reset", gen_reset, 0);

        // Second request held during a switch
        acc0 = accept_cnt;
        fork
            begin
                request(2'd1);
                request(2'd2);
            end
            begin
                repeat (4) tick();
                pulse_fs();
                repeat (8) tick();
                pulse_fs();
                repeat (3) tick();
                pulse_fs();
            end
        join
        @(negedge clk);
        chk("held_accepts",   accept_cnt - acc0, 2);
        chk("held_mode",      mode,      1);
        chk("held_req_ready", req_ready, 0);
        pulse_fs();
        repeat (8) tick();
        pulse_fs();
        tick();
        pulse_fs();
        @(negedge clk);
        chk("held_mode_final", mode,     2);
        chk("held_ack",        mode_ack, 1);

        // Reset during SETTLE
        request(2'd3);
        pulse_fs();
        repeat (8) tick();
        pulse_fs();
        ack0 = ack_cnt;
        #1 reset = 1'b1;
        #1;
        chk("midrst_mode",      mode,      0);
        chk("midrst_gen_reset", gen_reset, 1);
        chk("midrst_blank",     blank,     1);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        pulse_fs();
        pulse_fs();
        @(negedge clk);
        chk("midrst_no_ack", ack_cnt - ack0, 0);
        chk("midrst_busy",   busy,           0);

`ifdef VGA_MODE_CLKSEL_EN
        // Slow clock relock
        clk_locked = 1'b0;
        request(2'd2);
        pulse_fs();
        cnt = 0;
        for (int i = 0; i < 54; i++) begin
            @(negedge clk);
            cnt += int'(gen_reset);
        end
        tick();
        clk_locked = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt += int'(gen_reset);
        end
        chk("lock_gen_reset_cycles", cnt, 55);
        chk("lock_clk_sel", clk_sel, 2);
        pulse_fs();
        pulse_fs();
        @(negedge clk);
        chk("lock_ack", mode_ack, 1);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rdy = (req_ready === 1'b1);
            @(posedge clk);
            #2;
            if (req_valid && rdy) req_valid = 1'b0;
            if (!req_valid && $urandom_range(0, 5) == 0) begin
                req_valid = 1'b1;
                req_mode  = 2'($urandom_range(0, 3));
            end
            frame_start = ($urandom_range(0, 11) == 0);
            clk_locked  = LOCK_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
            reset       = ($urandom_range(0, 399) == 0);
        end
        req_valid   = 1'b0;
        frame_start = 1'b0;
        reset       = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
